// File: rtl/ram_access_arbiter_pkg.sv
// Shared constants for the RAM access arbiter: FSM states, access sizes, RW encoding, port ids.
// Also holds the alignment rule used at grant time.
package ram_access_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // Reserved size is treated as misaligned so it never reaches the RAM.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == SZ_HALF && addr_lo[0]) ||
               (size == SZ_WORD && addr_lo != 2'b00) ||
               (size == SZ_RSVD);
    endfunction

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Requester and RAM-side signal bundle of the arbiter.
// slave = arbiter view, master = requesters plus RAM (testbench view).
interface ram_access_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              ifReq;
    logic [ADDR_W-1:0] ifAddr;
    logic              ifDone;
    logic              ifErr;
    logic [DATA_W-1:0] ifRdata;

    logic              dReq;
    logic              dRW;
    logic [1:0]        dSize;
    logic [ADDR_W-1:0] dAddr;
    logic [DATA_W-1:0] dWdata;
    logic              dDone;
    logic              dErr;
    logic [DATA_W-1:0] dRdata;

    logic              ramMFA;
    logic              ramRW;
    logic [1:0]        ramDataSize;
    logic [ADDR_W-1:0] ramAddress;
    logic [DATA_W-1:0] ramDataOut;
    logic [DATA_W-1:0] ramDataIn;
    logic              ramMFC;
    logic              busy;

    modport slave (
        input  ifReq, ifAddr, dReq, dRW, dSize, dAddr, dWdata, ramDataIn, ramMFC,
        output ifDone, ifErr, ifRdata, dDone, dErr, dRdata,
               ramMFA, ramRW, ramDataSize, ramAddress, ramDataOut, busy
    );

    modport master (
        output ifReq, ifAddr, dReq, dRW, dSize, dAddr, dWdata, ramDataIn, ramMFC,
        input  ifDone, ifErr, ifRdata, dDone, dErr, dRdata,
               ramMFA, ramRW, ramDataSize, ramAddress, ramDataOut, busy
    );
endinterface

// File: rtl/ram_access_arbiter_sel.sv
// Combinational IF/D grant selector with a saturating D-streak counter for IF starvation relief.
// Grants only while idle; a misaligned D grant leaves the streak untouched.
module arb_priority_sel #(
    parameter int MAX_D_STREAK = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic idle_i,
    input  logic if_req_i,
    input  logic d_req_i,
    input  logic d_bad_i,
    output logic gnt_if_o,
    output logic gnt_d_o
);
    localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [SW-1:0] streak_q, streak_d;
    logic          force_if;

    assign force_if = (streak_q == STREAK_MAX);
    assign gnt_d_o  = idle_i && d_req_i && !(if_req_i && force_if);
    assign gnt_if_o = idle_i && if_req_i && !gnt_d_o;

    always_comb begin
        streak_d = streak_q;
        if (gnt_if_o) begin
            streak_d = '0;
        end else if (gnt_d_o && !d_bad_i && if_req_i && !force_if) begin
            streak_d = streak_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one MFA/MFC RAM port between fetch (IF) and load/store (D); RAM fields come from grant-time latches.
// Optional ARB_TIMEOUT_EN aborts an access with err=1 when MFC never arrives.
module ram_access_arbiter
    import ram_access_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 3,
    parameter int TIMEOUT      = 16
) (
    input  logic                 Clk,
    input  logic                 reset,
    ram_access_arbiter_if.slave  bus
);
    logic [1:0]        state_q, state_d;
    logic              port_q, rw_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, if_rdata_q, d_rdata_q;
    logic              if_done_q, if_err_q, d_done_q, d_err_q;

    logic gnt_if, gnt_d, d_bad, fin, fin_err, tmo_hit;

    assign d_bad = is_misaligned(bus.dSize, bus.dAddr[1:0]);

    arb_priority_sel #(.MAX_D_STREAK(MAX_D_STREAK)) u_sel (
        .clk      (Clk),
        .rst_n    (reset),
        .idle_i   (state_q == ST_IDLE),
        .if_req_i (bus.ifReq),
        .d_req_i  (bus.dReq),
        .d_bad_i  (d_bad),
        .gnt_if_o (gnt_if),
        .gnt_d_o  (gnt_d)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;

    assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else if (state_q != ST_ACCESS) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TW'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // An access finishes on MFC, or on timeout when MFC is still low.
    assign fin     = (state_q == ST_ACCESS) && (bus.ramMFC || tmo_hit);
    assign fin_err = !bus.ramMFC;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (gnt_if || (gnt_d && !d_bad)) state_d = ST_ACCESS;
            ST_ACCESS:  if (fin) state_d = ST_RELEASE;
            ST_RELEASE: if (!bus.ramMFC) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            port_q     <= PORT_IF;
            rw_q       <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_done_q  <= 1'b0;
            if_err_q   <= 1'b0;
            d_done_q   <= 1'b0;
            d_err_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            if_done_q <= fin && (port_q == PORT_IF);
            if_err_q  <= fin && (port_q == PORT_IF) && fin_err;
            d_done_q  <= (fin && (port_q == PORT_D)) || (gnt_d && d_bad);
            d_err_q   <= (fin && (port_q == PORT_D) && fin_err) || (gnt_d && d_bad);

            if (gnt_if) begin
                port_q  <= PORT_IF;
                addr_q  <= bus.ifAddr;
                rw_q    <= RD;
                size_q  <= SZ_WORD;
                wdata_q <= '0;
            end else if (gnt_d && !d_bad) begin
                port_q  <= PORT_D;
                addr_q  <= bus.dAddr;
                rw_q    <= bus.dRW;
                size_q  <= bus.dSize;
                wdata_q <= bus.dWdata;
            end

            if (fin && !fin_err && rw_q == RD) begin
                if (port_q == PORT_IF) begin
                    if_rdata_q <= bus.ramDataIn;
                end else begin
                    d_rdata_q <= bus.ramDataIn;
                end
            end
        end
    end

    assign bus.ramMFA      = (state_q == ST_ACCESS);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.ramRW       = rw_q;
    assign bus.ramDataSize = size_q;
    assign bus.ramAddress  = addr_q;
    assign bus.ramDataOut  = wdata_q;
    assign bus.ifDone      = if_done_q;
    assign bus.ifErr       = if_err_q;
    assign bus.ifRdata     = if_rdata_q;
    assign bus.dDone       = d_done_q;
    assign bus.dErr        = d_err_q;
    assign bus.dRdata      = d_rdata_q;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed and randomized checks of ram_access_arbiter against a RAM responder and a reference model.
// Optional ARB_TIMEOUT_EN section exercises the MFC timeout.
module tb_ram_access_arbiter;
    logic Clk = 1'b0;
    logic reset = 1'b0;
    always #5 Clk = ~Clk;

    ram_access_arbiter_if #(.ADDR_W(9), .DATA_W(32)) bus ();

    ram_access_arbiter #(
        .ADDR_W(9), .DATA_W(32), .MAX_D_STREAK(3), .TIMEOUT(16)
    ) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] ram_mem [0:511];
    logic [31:0] ref_mem [0:511];
    int  lat = 3;
    bit  hold_mfc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_done(input bit is_d, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (is_d ? bus.dDone : bus.ifDone) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // RAM responder: raises MFC lat cycles into MFA, drops it once MFA falls.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.ramMFC = 1'b0;
        bus.ramDataIn = '0;
        forever begin
            @(posedge Clk);
            #1;
            if (!reset) begin
                bus.ramMFC = 1'b0;
                wcnt = 0;
            end else if (bus.ramMFA && !bus.ramMFC) begin
                if (!hold_mfc) begin
                    wcnt++;
                    if (wcnt >= lat) begin
                        if (bus.ramRW) bus.ramDataIn = ram_mem[bus.ramAddress];
                        else ram_mem[bus.ramAddress] = bus.ramDataOut;
                        bus.ramMFC = 1'b1;
                        wcnt = 0;
                    end
                end
            end else if (!bus.ramMFA && bus.ramMFC) begin
                bus.ramMFC = 1'b0;
            end
        end
    end

    initial begin
        bit ok;
        bit got [$];
        bit expo [$];
        int mstreak;
        logic [31:0] exp_if_rdata, exp_d_rdata;
        int mfa_cnt;

        for (int i = 0; i < 512; i++) begin
            ram_mem[i] = $urandom;
            ref_mem[i] = ram_mem[i];
        end
        ram_mem[4] = 32'h0022_1820;
        ref_mem[4] = 32'h0022_1820;

        bus.ifReq = 0; bus.ifAddr = '0;
        bus.dReq = 0; bus.dRW = 0; bus.dSize = '0; bus.dAddr = '0; bus.dWdata = '0;

        // Reset state
        step(); step();
        chk("rst_mfa", bus.ramMFA, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ifdone", bus.ifDone, 0);
        chk("rst_ddone", bus.dDone, 0);
        chk("rst_ifrdata", bus.ifRdata, 0);
        chk("rst_drdata", bus.dRdata, 0);
        chk("rst_addr", bus.ramAddress, 0);
        chk("rst_dout", bus.ramDataOut, 0);
        reset = 1'b1;
        step();

        // Fetch
        bus.ifAddr = 9'h004; bus.ifReq = 1;
        step();
        chk("if_mfa", bus.ramMFA, 1);
        chk("if_rw", bus.ramRW, 1);
        chk("if_size", bus.ramDataSize, 2'b10);
        chk("if_addr", bus.ramAddress, 9'h004);
        wait_done(1'b0, 20, ok);
        chk("if_done_seen", ok, 1);
        bus.ifReq = 0;
        chk("if_err", bus.ifErr, 0);
        chk("if_rdata", bus.ifRdata, 32'h0022_1820);
        chk("if_mfa_drop", bus.ramMFA, 0);
        step();
        chk("if_done_pulse", bus.ifDone, 0);
        if (bus.busy) wait_idle(10, ok); else ok = 1'b1;
        chk("if_idle", ok, 1);

        // Halfword store; requester inputs change after the grant
        bus.dRW = 0; bus.dSize = 2'b01; bus.dAddr = 9'h010; bus.dWdata = 32'hBEEF; bus.dReq = 1;
        step();
        chk("dw_mfa", bus.ramMFA, 1);
        chk("dw_rw", bus.ramRW, 0);
        chk("dw_size", bus.ramDataSize, 2'b01);
        chk("dw_dout", bus.ramDataOut, 32'hBEEF);
        bus.dWdata = 32'h1234;
        step();
        chk("dw_dout_latched", bus.ramDataOut, 32'hBEEF);
        wait_done(1'b1, 20, ok);
        chk("dw_done_seen", ok, 1);
        bus.dReq = 0;
        chk("dw_err", bus.dErr, 0);
        ref_mem[16] = 32'hBEEF;
        chk("dw_mem", ram_mem[16], 32'hBEEF);
        wait_idle(10, ok);
        chk("dw_idle", ok, 1);

        // Misaligned word load
        bus.dRW = 1; bus.dSize = 2'b10; bus.dAddr = 9'h013; bus.dReq = 1;
        step();
        chk("mis_done", bus.dDone, 1);
        chk("mis_err", bus.dErr, 1);
        chk("mis_mfa", bus.ramMFA, 0);
        bus.dReq = 0;
        step();
        chk("mis_done_pulse", bus.dDone, 0);
        chk("mis_mfa2", bus.ramMFA, 0);
        chk("mis_busy", bus.busy, 0);

        // Fairness with both requests held
        lat = 2;
        bus.ifAddr = 9'h020;
        bus.dRW = 1; bus.dSize = 2'b10; bus.dAddr = 9'h040;
        bus.ifReq = 1; bus.dReq = 1;
        for (int i = 0; i < 200 && got.size() < 8; i++) begin
            step();
            if (bus.ifDone) got.push_back(1'b0);
            if (bus.dDone) got.push_back(1'b1);
        end
        bus.ifReq = 0; bus.dReq = 0;
        mstreak = 0;
        for (int i = 0; i < 8; i++) begin
            if (mstreak == 3) begin expo.push_back(1'b0); mstreak = 0; end
            else begin expo.push_back(1'b1); mstreak++; end
        end
        chk("order_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk($sformatf("order%0d", i), got[i], expo[i]);
        exp_if_rdata = ref_mem[9'h020];
        exp_d_rdata  = ref_mem[9'h040];
        wait_idle(10, ok);
        chk("fair_idle", ok, 1);

        // Randomized transactions against the reference model
        for (int it = 0; it < 40; it++) begin
            bit ir, dr, wd, bad, got_d;
            logic [1:0] r;
            r = 2'($urandom_range(1, 3));
            ir = r[0]; dr = r[1];
            lat = $urandom_range(1, 4);
            bus.ifAddr = 9'($urandom);
            bus.dAddr  = 9'($urandom);
            bus.dSize  = 2'($urandom_range(0, 3));
            bus.dRW    = 1'($urandom);
            bus.dWdata = $urandom;
            wd  = dr && (!ir || mstreak < 3);
            bad = (bus.dSize == 2'b11) || (bus.dSize == 2'b01 && bus.dAddr[0]) ||
                  (bus.dSize == 2'b10 && bus.dAddr[1:0] != 2'b00);
            if (wd) begin
                if (!bad && ir && mstreak < 3) mstreak++;
                if (!bad) begin
                    if (bus.dRW) exp_d_rdata = ref_mem[bus.dAddr];
                    else ref_mem[bus.dAddr] = bus.dWdata;
                end
            end else begin
                mstreak = 0;
                exp_if_rdata = ref_mem[bus.ifAddr];
            end
            bus.ifReq = ir; bus.dReq = dr;
            ok = 1'b0; got_d = 1'b0;
            for (int i = 0; i < 30; i++) begin
                step();
                if (bus.ifDone || bus.dDone) begin
                    ok = 1'b1;
                    got_d = bus.dDone;
                    break;
                end
            end
            bus.ifReq = 0; bus.dReq = 0;
            chk($sformatf("rnd%0d_done", it), ok, 1);
            chk($sformatf("rnd%0d_port", it), got_d, wd);
            chk($sformatf("rnd%0d_err", it), got_d ? bus.dErr : bus.ifErr, wd && bad);
            chk($sformatf("rnd%0d_ifrd", it), bus.ifRdata, exp_if_rdata);
            chk($sformatf("rnd%0d_drd", it), bus.dRdata, exp_d_rdata);
            if (wd && !bad && !bus.dRW)
                chk($sformatf("rnd%0d_mem", it), ram_mem[bus.dAddr], ref_mem[bus.dAddr]);
            if (bus.busy) begin
                wait_idle(10, ok);
                chk($sformatf("rnd%0d_idle", it), ok, 1);
            end
        end

        // Reset during an access
        lat = 3;
        hold_mfc = 1'b1;
        bus.ifAddr = 9'h008; bus.ifReq = 1;
        step();
        chk("rsta_mfa", bus.ramMFA, 1);
        step();
        #2 reset = 1'b0;
        #1;
        chk("rsta_mfa_drop", bus.ramMFA, 0);
        chk("rsta_busy", bus.busy, 0);
        chk("rsta_ifrdata", bus.ifRdata, 0);
        chk("rsta_drdata", bus.dRdata, 0);
        chk("rsta_addr", bus.ramAddress, 0);
        chk("rsta_rw", bus.ramRW, 0);
        chk("rsta_size", bus.ramDataSize, 0);
        chk("rsta_ifdone", bus.ifDone, 0);
        bus.ifReq = 0;
        hold_mfc = 1'b0;
        step(); step();
        reset = 1'b1;
        exp_d_rdata = '0;
        bus.ifReq = 1;
        wait_done(1'b0, 20, ok);
        bus.ifReq = 0;
        chk("rstb_done_seen", ok, 1);
        chk("rstb_err", bus.ifErr, 0);
        chk("rstb_rdata", bus.ifRdata, ref_mem[9'h008]);
        wait_idle(10, ok);
        chk("rstb_idle", ok, 1);

`ifdef ARB_TIMEOUT_EN
        hold_mfc = 1'b1;
        bus.dRW = 1; bus.dSize = 2'b10; bus.dAddr = 9'h044; bus.dReq = 1;
        step();
        mfa_cnt = 0;
        while (bus.ramMFA && mfa_cnt < 100) begin
            mfa_cnt++;
            step();
        end
        bus.dReq = 0;
        chk("tmo_mfa_cycles", mfa_cnt, 16);
        chk("tmo_done", bus.dDone, 1);
        chk("tmo_err", bus.dErr, 1);
        chk("tmo_rdata", bus.dRdata, exp_d_rdata);
        hold_mfc = 1'b0;
        wait_idle(10, ok);
        chk("tmo_idle", ok, 1);
`else
        mfa_cnt = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Shares the single RAM port between two requesters: the instruction-fetch requester (IF) and the load/store data requester (D).
- Sequences the RAM MFA/MFC handshake: raises ramMFA, waits for ramMFC, captures read data, then waits for ramMFC to drop.
- Sits between the control unit's fetch/memory states and the RAM. The control unit issues requests and stalls on per-port done pulses instead of driving ramMFA, ramRW, ramAddress and ramDataSize directly.

Parameters:
- ADDR_W, 9, RAM address width.
- DATA_W, 32, data width.
- MAX_D_STREAK, 3, consecutive D grants allowed while IF is pending before IF is forced.
- TIMEOUT, 16, MFC wait limit in cycles. Used only with ARB_TIMEOUT_EN.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ifReq  in  1  fetch request; held until ifDone.
- ifAddr  in  ADDR_W  fetch address; always a word read.
- ifDone  out  1  one-cycle completion pulse.
- ifErr  out  1  valid with ifDone.
- ifRdata  out  DATA_W  fetched word; held until the next IF completion.
- dReq  in  1  data request; held until dDone.
- dRW  in  1  1 = read, 0 = write (ramRW encoding).
- dSize  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- dAddr  in  ADDR_W  data address.
- dWdata  in  DATA_W  store data.
- dDone  out  1  one-cycle completion pulse.
- dErr  out  1  valid with dDone.
- dRdata  out  DATA_W  load data; held until the next D completion.
- ramMFA  out  1  memory function activate.
- ramRW  out  1  to RAM.
- ramDataSize  out  2  to RAM.
- ramAddress  out  ADDR_W  to RAM.
- ramDataOut  out  DATA_W  to RAM.
- ramDataIn  in  DATA_W  from RAM.
- ramMFC  in  1  memory function complete.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, streak=0.
  - All outputs 0: ramMFA, done/err pulses, rdata registers, ramAddress/ramRW/ramDataSize/ramDataOut.
  - Reset asserted mid-access drops ramMFA immediately. The in-flight access is lost and no done pulse is issued.
- States: IDLE, ACCESS, RELEASE.
- IDLE, no request: stay in IDLE.
- IDLE, request present, grant selection:
  - Only one of ifReq/dReq is high: that port wins.
  - Both high: D wins unless streak==MAX_D_STREAK, in which case IF wins.
  - streak increments on each D grant made while ifReq=1, clears on any IF grant, and saturates at MAX_D_STREAK.
- IDLE, on grant: latch port id, address, rw, size and wdata into internal registers. RAM outputs are driven only from these registers, so requester inputs may change after the grant. Go to ACCESS.
- Alignment check at grant (D only):
  - Misaligned means size=01 with addr[0]=1, size=10 with addr[1:0]!=0, or size=11.
  - A misaligned request makes no RAM access. dDone=1 and dErr=1 the next cycle, state stays IDLE, streak is unchanged.
- ACCESS:
  - ramMFA=1.
  - When ramMFC is sampled 1: a read loads ramDataIn into the granted port's rdata register. The granted port's done pulses for exactly the next cycle with err=0. ramMFA drops to 0 in that same cycle. Go to RELEASE.
- RELEASE:
  - ramMFA=0.
  - Stay until ramMFC is sampled 0, then go to IDLE.
  - A new grant can therefore be made no earlier than the cycle after MFC falls.
- Latency: request sampled at edge k in IDLE → ramMFA high from edge k+1. MFC sampled high at edge m → done high in cycle m+1.
- A requester dropping req during ACCESS does not abort; the access completes and done still pulses.
- Fetch access fields: ramRW=1, ramDataSize=10.
- During ACCESS and RELEASE, IF and D requests are ignored. A request held through the access is granted in the first IDLE cycle after.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in ACCESS.
  - If ramMFC has not been seen after TIMEOUT cycles, drop ramMFA and pulse the granted port's done with err=1.
  - The rdata register is unchanged. Go to RELEASE.
- Undefined: ACCESS waits indefinitely for ramMFC, and err is only ever set by misalignment.

Decomposition:
- Shared package (e.g. memory package) holds:
  - state enum IDLE/ACCESS/RELEASE;
  - size constants SZ_BYTE=00, SZ_HALF=01, SZ_WORD=10;
  - RW constants RD=1, WR=0;
  - port id constants PORT_IF/PORT_D.
- One natural sub-module: arb_priority_sel, the combinational grant selector plus streak counter. The FSM and handshake stay in the top module.

Test Plan:
- Only ifReq=1 with ifAddr=0x004; RAM raises MFC 3 cycles after MFA with ramDataIn=0x00221820 → ramMFA 1, ramRW 1, ramDataSize 10, ramAddress 0x004; ifDone pulses 1 cycle; ifRdata=0x00221820; busy clears after MFC drops.
- dReq=1 with dRW=0, dSize=01, dAddr=0x010, dWdata=0xBEEF → ramRW 0, ramDataSize 01, ramDataOut 0xBEEF; dDone=1 and dErr=0 after MFC.
- ifReq and dReq held high continuously, MFC at 2-cycle latency → grant order D,D,D,IF,D,D,D,IF.
- dSize=10 with dAddr=0x013 → ramMFA never rises; dDone=1 and dErr=1 one cycle after the request.
- reset driven 0 while in ACCESS → ramMFA 0 immediately and all outputs 0. After release, a new ifReq is serviced normally.
- With ARB_TIMEOUT_EN and ramMFC held 0 → ramMFA drops after 16 cycles; done=1 and err=1 for the granted port.
